// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 clock controller.
//   clk_state_e     : controller mode (single-step, free-run, halted)
//   RUN_DIV_DEFAULT : default clk cycles between clk_en pulses in run mode
package sap_pkg;
  typedef enum logic [1:0] {
    STEP   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } clk_state_e;

  localparam int RUN_DIV_DEFAULT = 25_000_000;
endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector on an already-debounced level.
//   clk, rst_n : clock, async active-low reset
//   d          : input level
//   rise       : 1 while d=1 and the previous sampled level was 0
// RESET_VAL=1 suppresses a spurious edge from a button held through reset.
module edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RESET_VAL;
    else        prev <= d;
  end

  assign rise = d & ~prev;
endmodule

// File: rtl/sap_clock_ctrl.sv
// SAP-1 clock controller: turns debounced button/switch levels into
// single-cycle clock-enable and clear pulses for the core.
//   clk, rst_n : clock, async active-low reset
//   step_btn   : step button level (1=pressed)
//   clr_btn    : clear button level (1=pressed)
//   run_sw     : mode switch (1=run, 0=step)
//   hlt        : halt request from the control unit
//   clk_en     : one-cycle core advance pulse (registered)
//   cpu_clr    : one-cycle core clear pulse (registered)
//   halted     : 1 in HALTED
//   mode_run   : 1 in RUN
module sap_clock_ctrl
  import sap_pkg::*;
#(
  parameter int RUN_DIV = RUN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_btn,
  input  logic clr_btn,
  input  logic run_sw,
  input  logic hlt,
  output logic clk_en,
  output logic cpu_clr,
  output logic halted,
  output logic mode_run
);
  localparam int CNT_W = $clog2(RUN_DIV);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(RUN_DIV - 1);

  clk_state_e       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             nxt_clk_en, nxt_clr;
  logic             step_rise, clr_rise;

  edge_rise #(.RESET_VAL(1'b1)) u_step_edge (
    .clk(clk), .rst_n(rst_n), .d(step_btn), .rise(step_rise)
  );

  edge_rise #(.RESET_VAL(1'b1)) u_clr_edge (
    .clk(clk), .rst_n(rst_n), .d(clr_btn), .rise(clr_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STEP;
      cnt     <= '0;
      clk_en  <= 1'b0;
      cpu_clr <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      clk_en  <= nxt_clk_en;
      cpu_clr <= nxt_clr;
    end
  end

  // Priority: clr edge > hlt > mode change > step edge / terminal count.
  // Any mode transition zeroes the divider so RUN always starts a full period.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_clk_en = 1'b0;
    nxt_clr    = 1'b0;
    if (clr_rise) begin
      nxt_clr   = 1'b1;
      nxt_cnt   = '0;
      nxt_state = run_sw ? RUN : STEP;
    end else if (state == HALTED) begin
      nxt_cnt = '0;
    end else if (hlt) begin
      nxt_state = HALTED;
      nxt_cnt   = '0;
    end else begin
      case (state)
        STEP: begin
          if (run_sw) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
          end else if (step_rise) begin
            nxt_clk_en = 1'b1;
          end
        end
        RUN: begin
          if (!run_sw) begin
            nxt_state = STEP;
            nxt_cnt   = '0;
          end else if (cnt == CNT_TC) begin
            nxt_clk_en = 1'b1;
            nxt_cnt    = '0;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        default: begin
          nxt_state = STEP;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  assign mode_run = (state == RUN);
  assign halted   = (state == HALTED);
endmodule
